// File: rtl/adau_spi_pkg.sv
// Shared definitions for the ADAU control-port SPI link (slave and master sides).
// Frame layout: {chip_addr[6:0], rw, subaddr[15:0], data[7:0]}, MSB first.
package adau_spi_pkg;

    localparam int unsigned FRAME_BITS    = 32;
    localparam int unsigned READ_HDR_BITS = 24;
    localparam int unsigned ADDR_MSB      = 31;
    localparam int unsigned RW_BIT        = 24;
    localparam int unsigned SUB_MSB       = 23;
    localparam int unsigned DATA_MSB      = 7;
    localparam int unsigned ADDR_BITS     = 7;
    localparam int unsigned SUB_BITS      = 16;

    typedef enum logic [2:0] {
        StWaitHigh,
        StIdle,
        StShift,
        StReadLoad,
        StReadOut
    } spi_state_e;

endpackage

// File: rtl/adau_sync_edge.sv
// N-stage synchronizer for an asynchronous pin, plus single-cycle rise/fall pulses
// derived from the synchronized value and its one-cycle-delayed copy.
module adau_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter bit          RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], din};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign dout = chain_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/adau_spi_slave.sv
// ADAU control-port SPI responder: collects 32-bit write frames onto a valid/ready
// stream and answers 1-byte read frames from an external register-file lookup.
module adau_spi_slave
    import adau_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  CHIP_ADDR   = 7'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cclk,
    input  logic        cdata,
    input  logic        clatch_n,
    output logic        cout,
    output logic [31:0] data_out,
    output logic        valid,
    input  logic        ready,
    output logic [15:0] rd_addr,
    output logic        rd_req,
    input  logic [7:0]  rd_data,
    output logic        frame_err
);

    localparam int unsigned HDR_SHIFT  = FRAME_BITS - READ_HDR_BITS;
    localparam logic [5:0]  FrameCnt   = 6'(FRAME_BITS);
    localparam logic [5:0]  LastHdrCnt = 6'(READ_HDR_BITS - 1);

    logic cclk_rise, cclk_fall, cclk_s;
    logic latch_rise, latch_fall, latch_s;
    logic cdata_s, cdata_rise_unused, cdata_fall_unused;

    adau_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cclk (
        .clk   (clk),
        .reset (reset),
        .din   (cclk),
        .dout  (cclk_s),
        .rise  (cclk_rise),
        .fall  (cclk_fall)
    );

    // Resets low so a frame already in progress at reset release never looks like a new one.
    adau_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_latch (
        .clk   (clk),
        .reset (reset),
        .din   (clatch_n),
        .dout  (latch_s),
        .rise  (latch_rise),
        .fall  (latch_fall)
    );

    adau_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cdata (
        .clk   (clk),
        .reset (reset),
        .din   (cdata),
        .dout  (cdata_s),
        .rise  (cdata_rise_unused),
        .fall  (cdata_fall_unused)
    );

    spi_state_e  state_q, state_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic        first_fall_q, first_fall_d;
    logic        cout_q, cout_d;
    logic [31:0] data_out_q, data_out_d;
    logic        valid_q, valid_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic        rd_req_q, rd_req_d;
    logic        frame_err_q, frame_err_d;

    logic [31:0] shift_in;
    logic [5:0]  bitcnt_inc;
    logic        hdr_read_in;
    logic        wr_match_q;

    assign shift_in    = {shift_q[30:0], cdata_s};
    assign bitcnt_inc  = (bitcnt_q == 6'd63) ? bitcnt_q : bitcnt_q + 6'd1;
    assign hdr_read_in = (shift_in[ADDR_MSB-HDR_SHIFT -: ADDR_BITS] == CHIP_ADDR)
                         && shift_in[RW_BIT-HDR_SHIFT];
    assign wr_match_q  = (shift_q[ADDR_MSB -: ADDR_BITS] == CHIP_ADDR) && !shift_q[RW_BIT];

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        first_fall_d = first_fall_q;
        cout_d       = cout_q;
        data_out_d   = data_out_q;
        valid_d      = valid_q && !ready;
        rd_addr_d    = rd_addr_q;
        rd_req_d     = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            StWaitHigh: begin
                if (latch_s) state_d = StIdle;
            end
            StIdle: begin
                if (latch_fall) begin
                    state_d  = StShift;
                    bitcnt_d = '0;
                    shift_d  = '0;
                end
            end
            StShift: begin
                // Latch rise takes priority over a coincident cclk edge.
                if (latch_rise) begin
                    state_d = StIdle;
                    if (bitcnt_q != FrameCnt) begin
                        frame_err_d = 1'b1;
                    end else if (wr_match_q) begin
                        if (valid_q && !ready) begin
                            frame_err_d = 1'b1;
                        end else begin
                            data_out_d = shift_q;
                            valid_d    = 1'b1;
                        end
                    end
                end else begin
                    if (cclk_rise) begin
                        shift_d  = shift_in;
                        bitcnt_d = bitcnt_inc;
                        if (bitcnt_q == LastHdrCnt && hdr_read_in) begin
                            rd_req_d  = 1'b1;
                            rd_addr_d = shift_in[SUB_MSB-HDR_SHIFT -: SUB_BITS];
                        end
                    end
                    // rd_data is captured in READ_LOAD, the cycle after the rd_req pulse.
                    if (rd_req_q) state_d = StReadLoad;
                end
            end
            StReadLoad, StReadOut: begin
                if (latch_rise) begin
                    state_d = StIdle;
                    cout_d  = 1'b0;
                    if (bitcnt_q != FrameCnt) frame_err_d = 1'b1;
                end else begin
                    if (cclk_rise) bitcnt_d = bitcnt_inc;
                    if (state_q == StReadLoad) begin
                        tx_d         = rd_data;
                        cout_d       = rd_data[DATA_MSB];
                        first_fall_d = 1'b1;
                        state_d      = StReadOut;
                    end else if (cclk_fall) begin
                        if (first_fall_q) begin
                            first_fall_d = 1'b0;
                        end else begin
                            tx_d   = {tx_q[6:0], 1'b0};
                            cout_d = tx_q[6];
                        end
                    end
                end
            end
            default: state_d = StWaitHigh;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StWaitHigh;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            tx_q         <= '0;
            first_fall_q <= 1'b0;
            cout_q       <= 1'b0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_req_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            first_fall_q <= first_fall_d;
            cout_q       <= cout_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            rd_addr_q    <= rd_addr_d;
            rd_req_q     <= rd_req_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign cout      = cout_q;
    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign rd_addr   = rd_addr_q;
    assign rd_req    = rd_req_q;
    assign frame_err = frame_err_q;

endmodule
